// File: rtl/noc_telemetry_pkg.sv
// Shared definitions for the router telemetry sampler: port indices, FSM
// state encoding, snapshot record layout and the wrap-safe delta helper.
package noc_telemetry_pkg;

    // Default configuration of the sampler.
    localparam int TEL_NUM_PORTS  = 5;
    localparam int TEL_CTR_W      = 32;
    localparam int TEL_DELTA_W    = 16;
    localparam int TEL_WIN_W      = 16;
    localparam int TEL_FIFO_DEPTH = 4;
    localparam int TEL_SEQ_W      = 8;

    // Router port order inside every packed counter/delta bus (slice 0 = N).
    localparam int PORT_N = 0;
    localparam int PORT_S = 1;
    localparam int PORT_E = 2;
    localparam int PORT_W = 3;
    localparam int PORT_L = 4;

    // Counter kinds, in the order they are concatenated inside a record.
    localparam int KIND_IN    = 0;
    localparam int KIND_OUT   = 1;
    localparam int KIND_STALL = 2;

    // Sampler FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } samp_state_e;

    // Record layout for the default configuration, LSB first:
    // in deltas | out deltas | stall deltas | sat | seq
    localparam int REC_BLK_W     = TEL_NUM_PORTS * TEL_DELTA_W;
    localparam int REC_IN_OFF    = 0;
    localparam int REC_OUT_OFF   = REC_BLK_W;
    localparam int REC_STALL_OFF = 2 * REC_BLK_W;
    localparam int REC_SAT_OFF   = 3 * REC_BLK_W;
    localparam int REC_SEQ_OFF   = REC_SAT_OFF + 1;
    localparam int REC_W         = REC_SEQ_OFF + TEL_SEQ_W;

    // Modular difference of two free-running counters, clamped to the delta
    // width. Returns {sat, delta}; sat is set when the clamp was applied.
    // Counter wrap is absorbed by the modular subtraction and is not flagged.
    function automatic logic [TEL_DELTA_W:0] sat_delta(
        input logic [TEL_CTR_W-1:0] cur,
        input logic [TEL_CTR_W-1:0] base
    );
        logic [TEL_CTR_W-1:0] diff;
        diff = cur - base;
        if (|diff[TEL_CTR_W-1:TEL_DELTA_W]) begin
            return {1'b1, {TEL_DELTA_W{1'b1}}};
        end
        return {1'b0, diff[TEL_DELTA_W-1:0]};
    endfunction

endpackage

// File: rtl/telemetry_snap_fifo.sv
// Small first-word-fall-through FIFO carrying packed snapshot records.
// The head entry is presented on data_o while valid_o is high and stays
// stable until it is popped. A push into a full FIFO is accepted only when
// a pop happens on the same edge; otherwise it is reported on overflow_o.
module telemetry_snap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop     = pop_i && !empty;
    assign do_push    = push_i && (!full || do_pop);
    assign overflow_o = push_i && full && !do_pop;

    // Pointer advance for accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Record storage; contents are only observable through valid entries,
    // so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    // Head of queue falls through; an empty FIFO presents all zeros.
    assign valid_o = !empty;
    assign data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/router_telemetry_sampler.sv
// Router telemetry sampler: turns the router's free-running per-port
// ingress/egress/stall counters into per-window deltas, packs them into
// sequence-numbered records and streams them out through a small FIFO.
module router_telemetry_sampler
    import noc_telemetry_pkg::*;
#(
    parameter int NUM_PORTS  = TEL_NUM_PORTS,
    parameter int CTR_W      = TEL_CTR_W,
    parameter int DELTA_W    = TEL_DELTA_W,
    parameter int WIN_W      = TEL_WIN_W,
    parameter int FIFO_DEPTH = TEL_FIFO_DEPTH,
    parameter int SEQ_W      = TEL_SEQ_W
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic [WIN_W-1:0]               window_len,
    input  logic [NUM_PORTS*CTR_W-1:0]     in_ctrs,
    input  logic [NUM_PORTS*CTR_W-1:0]     out_ctrs,
    input  logic [NUM_PORTS*CTR_W-1:0]     stall_ctrs,
    output logic                           snap_valid,
    input  logic                           snap_ready,
    output logic [SEQ_W-1:0]               snap_seq,
    output logic [NUM_PORTS*DELTA_W-1:0]   snap_in_delta,
    output logic [NUM_PORTS*DELTA_W-1:0]   snap_out_delta,
    output logic [NUM_PORTS*DELTA_W-1:0]   snap_stall_delta,
    output logic                           snap_sat,
    output logic [15:0]                    drop_count,
    output logic                           busy
);

    // All three counter kinds are handled as one flat vector of NCTR lanes:
    // lanes [0, NUM_PORTS) are ingress, then egress, then stall.
    localparam int NCTR      = 3 * NUM_PORTS;
    localparam int BLK_W     = NUM_PORTS * DELTA_W;
    localparam int IN_OFF    = 0;
    localparam int OUT_OFF   = BLK_W;
    localparam int STALL_OFF = 2 * BLK_W;
    localparam int SAT_OFF   = 3 * BLK_W;
    localparam int SEQ_OFF   = SAT_OFF + 1;
    localparam int REC_WIDTH = SEQ_OFF + SEQ_W;

    samp_state_e              state_q, state_d;
    logic [WIN_W-1:0]         win_cnt_q, win_cnt_d;
    logic [WIN_W-1:0]         win_last;
    logic [SEQ_W-1:0]         seq_q, seq_d;
    logic [NCTR*CTR_W-1:0]    cur_all;
    logic [NCTR*CTR_W-1:0]    base_q, base_d;
    logic [NCTR*DELTA_W-1:0]  delta_all;
    logic [NCTR-1:0]          sat_vec;
    logic                     capture;
    logic [15:0]              drop_q, drop_d;
    logic [REC_WIDTH-1:0]     rec_in;
    logic [REC_WIDTH-1:0]     rec_out;
    logic                     fifo_valid;
    logic                     fifo_overflow;

    assign cur_all = {stall_ctrs, out_ctrs, in_ctrs};

    // Last win_cnt value of a window. Lengths 0 and 1 behave as 2. The
    // compare is an equality, so shrinking window_len below the current
    // count lets the window run on until win_cnt wraps around.
    assign win_last = (window_len < WIN_W'(2)) ? WIN_W'(1)
                                               : (window_len - WIN_W'(1));

    // Per-lane wrap-safe delta against the window baseline.
    generate
        for (genvar gi = 0; gi < NCTR; gi++) begin : g_delta
            logic [DELTA_W:0] sd;
            assign sd = sat_delta(cur_all[gi*CTR_W +: CTR_W],
                                  base_q[gi*CTR_W +: CTR_W]);
            assign delta_all[gi*DELTA_W +: DELTA_W] = sd[DELTA_W-1:0];
            assign sat_vec[gi] = sd[DELTA_W];
        end
    endgenerate

    // The record carries the sequence number of the window it closes.
    assign rec_in = {seq_q, |sat_vec, delta_all};

    // Sampling FSM: ARM takes the baseline, RUN counts the window and
    // closes it with a capture; dropping enable abandons the open window.
    always_comb begin
        state_d   = state_q;
        win_cnt_d = win_cnt_q;
        seq_d     = seq_q;
        base_d    = base_q;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    base_d    = cur_all;
                    win_cnt_d = '0;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (win_cnt_q == win_last) begin
                    // Window boundary: next window starts from these values
                    // with no gap, and the sequence advances even if the
                    // record ends up dropped.
                    capture   = 1'b1;
                    base_d    = cur_all;
                    win_cnt_d = '0;
                    seq_d     = seq_q + SEQ_W'(1);
                end else begin
                    win_cnt_d = win_cnt_q + WIN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Saturating count of records that found the FIFO full.
    always_comb begin
        drop_d = drop_q;
        if (fifo_overflow && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    // Sampler state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            win_cnt_q <= '0;
            seq_q     <= '0;
            base_q    <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            win_cnt_q <= win_cnt_d;
            seq_q     <= seq_d;
            base_q    <= base_d;
            drop_q    <= drop_d;
        end
    end

    telemetry_snap_fifo #(
        .WIDTH (REC_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_snap_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (capture),
        .data_i     (rec_in),
        .pop_i      (snap_ready),
        .valid_o    (fifo_valid),
        .data_o     (rec_out),
        .overflow_o (fifo_overflow)
    );

    assign snap_valid       = fifo_valid;
    assign snap_seq         = rec_out[SEQ_OFF +: SEQ_W];
    assign snap_sat         = rec_out[SAT_OFF];
    assign snap_in_delta    = rec_out[IN_OFF +: BLK_W];
    assign snap_out_delta   = rec_out[OUT_OFF +: BLK_W];
    assign snap_stall_delta = rec_out[STALL_OFF +: BLK_W];
    assign drop_count       = drop_q;
    assign busy             = (state_q != ST_IDLE);

endmodule
